// File: rtl/flash_seq_pkg.sv
// Flash sample sequencer shared definitions:
// FSM state codes and default flash geometry.
package flash_seq_pkg;

   localparam int          ADDR_W_DEF   = 23;
   localparam logic [22:0] MAX_ADDR_DEF = 23'h7FFFF;

   typedef logic [2:0] state_t;

   localparam state_t IDLE     = 3'd0;
   localparam state_t REQ      = 3'd1;
   localparam state_t WAIT_RDY = 3'd2;
   localparam state_t WAIT_T1  = 3'd3;
   localparam state_t WAIT_T2  = 3'd4;
   localparam state_t ADVANCE  = 3'd5;

endpackage

// File: rtl/flash_sample_sequencer_addr_updown.sv
// Up/down flash word-address counter with load.
// At the end of range it either wraps or holds.
module addr_updown #(
   parameter int                ADDR_W   = 23,
   parameter logic [ADDR_W-1:0] MAX_ADDR = '1,
   parameter bit                WRAP     = 1'b0
) (
   input  logic              inclk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              step,
   input  logic              down,
   output logic [ADDR_W-1:0] addr,
   output logic              at_bound
);

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   assign at_bound = down ? (addr == '0) : (addr == MAX_ADDR);

   // load beats step; a step at the boundary wraps or holds
   always_ff @(posedge inclk or negedge reset) begin
      if (!reset) begin
         addr <= '0;
      end else if (load) begin
         addr <= load_val;
      end else if (step) begin
         if (at_bound) begin
            if (WRAP) addr <= down ? MAX_ADDR : '0;
         end else if (down) begin
            addr <= addr - ONE;
         end else begin
            addr <= addr + ONE;
         end
      end
   end

endmodule

// File: rtl/flash_sample_sequencer.sv
// Streams 16-bit audio samples out of 32-bit flash words.
// Define SEQ_LOOP_EN to wrap at the ends instead of stopping.
module flash_sample_sequencer
   import flash_seq_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MAX_ADDR_DEF)
) (
   input  logic              inclk,
   input  logic              reset,
   input  logic              sample_tick,
   input  logic              play,
   input  logic              dir,
   input  logic              restart,
   input  logic              read_ready,
   input  logic [31:0]       flash_readdata,
   output logic              read_start,
   output logic [ADDR_W-1:0] flash_address,
   output logic [15:0]       audio_sample,
   output logic              sample_valid,
   output logic              done
);

`ifdef SEQ_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   state_t      state;
   logic [31:0] word_q;
   logic        dir_q;
   logic        pend;
   logic        done_q;
   logic        apply;
   logic        tick_ok;
   logic        adv_step;
   logic        at_bound;
   logic        st_idle, st_req, st_wrdy;
   logic        st_t1, st_t2, st_adv;

   assign st_idle = (state == IDLE);
   assign st_req  = (state == REQ);
   assign st_wrdy = (state == WAIT_RDY);
   assign st_t1   = (state == WAIT_T1);
   assign st_t2   = (state == WAIT_T2);
   assign st_adv  = (state == ADVANCE);

   // a pending restart waits for the in-flight read to finish
   assign apply    = pend && (!st_wrdy || read_ready);
   assign tick_ok  = sample_tick && play && !restart;
   assign adv_step = st_adv && !apply && (LOOP || !at_bound);

   assign read_start = st_req && !pend;

`ifdef SEQ_LOOP_EN
   assign done = 1'b0;
`else
   assign done = done_q;
`endif

   addr_updown #(
      .ADDR_W   (ADDR_W),
      .MAX_ADDR (MAX_ADDR),
      .WRAP     (LOOP)
   ) u_addr (
      .inclk    (inclk),
      .reset    (reset),
      .load     (apply),
      .load_val (dir ? MAX_ADDR : '0),
      .step     (adv_step),
      .down     (dir_q),
      .addr     (flash_address),
      .at_bound (at_bound)
   );

   // sequencing FSM, restart has priority over everything
   always_ff @(posedge inclk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         word_q       <= '0;
         dir_q        <= 1'b0;
         audio_sample <= '0;
         sample_valid <= 1'b0;
         done_q       <= 1'b0;
         pend         <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         if (restart) pend <= 1'b1;
         if (apply) begin
            pend   <= restart;
            done_q <= 1'b0;
            state  <= play ? REQ : IDLE;
         end else begin
            unique case (1'b1)
               st_idle: begin
                  if (play && !done_q) state <= REQ;
               end
               st_req: begin
                  state <= WAIT_RDY;
               end
               st_wrdy: begin
                  if (read_ready) begin
                     word_q <= flash_readdata;
                     dir_q  <= dir;
                     state  <= WAIT_T1;
                  end
               end
               st_t1: begin
                  if (tick_ok) begin
                     audio_sample <= dir_q ? word_q[31:16]
                                           : word_q[15:0];
                     sample_valid <= 1'b1;
                     state        <= WAIT_T2;
                  end
               end
               st_t2: begin
                  if (tick_ok) begin
                     audio_sample <= dir_q ? word_q[15:0]
                                           : word_q[31:16];
                     sample_valid <= 1'b1;
                     state        <= ADVANCE;
                  end
               end
               st_adv: begin
                  if (!LOOP && at_bound) begin
                     done_q <= 1'b1;
                     state  <= IDLE;
                  end else begin
                     state <= REQ;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_flash_sample_sequencer.sv
// Bench for flash_sample_sequencer: directed scenarios
// followed by a randomized run against a stream model.
module tb_flash_sample_sequencer;

   localparam logic [22:0] MAX = 23'h7FFFF;

   logic        inclk;
   logic        reset;
   logic        sample_tick;
   logic        play;
   logic        dir;
   logic        restart;
   wire         read_ready;
   logic [31:0] flash_readdata;
   logic        read_start;
   logic [22:0] flash_address;
   logic [15:0] audio_sample;
   logic        sample_valid;
   logic        done;

   logic        rdy_auto;
   logic        rdy_man;
   logic [31:0] rd_word;
   logic [31:0] ovr_word;
   bit          ovr_en;
   int          resp_dly;
   int          resp_cnt;
   bit          sb_en;

   int n_vec;
   int n_err;
   int n_rs;

   assign read_ready = rdy_auto | rdy_man;

   flash_sample_sequencer dut (
      .inclk          (inclk),
      .reset          (reset),
      .sample_tick    (sample_tick),
      .play           (play),
      .dir            (dir),
      .restart        (restart),
      .read_ready     (read_ready),
      .flash_readdata (flash_readdata),
      .read_start     (read_start),
      .flash_address  (flash_address),
      .audio_sample   (audio_sample),
      .sample_valid   (sample_valid),
      .done           (done)
   );

   initial begin
      inclk = 1'b0;
      forever #5 inclk = ~inclk;
   end

   function automatic logic [31:0] mem_word(input logic [22:0] a);
      return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
   endfunction

   task automatic check_eq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step_clk();
      @(posedge inclk);
      #1;
   endtask

   task automatic tick();
      sample_tick = 1'b1;
      step_clk();
      sample_tick = 1'b0;
   endtask

   task automatic wait_rs(input string tag);
      int n;
      n = 0;
      while (read_start !== 1'b1 && n < 60) begin
         step_clk();
         n++;
      end
      check_eq(tag, read_start, 1);
   endtask

   // flash read FSM stand-in
   initial begin
      rdy_auto       = 1'b0;
      flash_readdata = '0;
      rd_word        = '0;
      resp_cnt       = 0;
      forever begin
         @(posedge inclk);
         #1;
         rdy_auto = 1'b0;
         if (!reset) begin
            resp_cnt = 0;
         end else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               rdy_auto       = 1'b1;
               flash_readdata = rd_word;
            end
         end else if (read_start) begin
            resp_cnt = (resp_dly > 0) ? resp_dly
                                      : int'($urandom_range(1, 4));
            rd_word  = ovr_en ? ovr_word : mem_word(flash_address);
         end
      end
   end

   // stream model: expected samples, next fetch address, done
   logic [15:0] exp_q[$];
   logic [22:0] m_addr;
   bit          m_done;
   bit          tp_prev;
   bit          avail_prev;
   bit          rs_due;
   bit          rs_due_nx;
   bit          fetched;
   logic [15:0] exp_s;

   initial begin
      forever begin
         @(negedge inclk);
         if (!sb_en) begin
            exp_q.delete();
            m_addr     = '0;
            m_done     = 1'b0;
            tp_prev    = 1'b0;
            avail_prev = 1'b0;
            rs_due     = 1'b0;
            fetched    = 1'b0;
         end else begin
            rs_due_nx = 1'b0;
            check_eq("sv", sample_valid, tp_prev && avail_prev);
            if (sample_valid) begin
               check_eq("q_nonempty", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  exp_s = exp_q.pop_front();
                  check_eq("sample", audio_sample, exp_s);
                  if (exp_q.size() == 0) rs_due_nx = 1'b1;
               end
            end
            if (rs_due) begin
               check_eq("rs_lat", read_start, !m_done);
               check_eq("done", done, m_done);
            end else if (read_start) begin
               check_eq("rs_spur", fetched, 0);
            end
            if (read_start) begin
               check_eq("rs_addr", flash_address, m_addr);
               check_eq("rs_qempty", exp_q.size(), 0);
               fetched = 1'b1;
            end
            rs_due     = rs_due_nx;
            tp_prev    = sample_tick && play && !restart;
            avail_prev = exp_q.size() > 0;
            if (read_ready) begin
               if (!dir) begin
                  exp_q.push_back(mem_word(m_addr) & 32'hFFFF);
                  exp_q.push_back(mem_word(m_addr) >> 16);
                  if (m_addr == MAX) begin
`ifdef SEQ_LOOP_EN
                     m_addr = '0;
`else
                     m_done = 1'b1;
`endif
                  end else begin
                     m_addr = m_addr + 23'd1;
                  end
               end else begin
                  exp_q.push_back(mem_word(m_addr) >> 16);
                  exp_q.push_back(mem_word(m_addr) & 32'hFFFF);
                  if (m_addr == '0) begin
`ifdef SEQ_LOOP_EN
                     m_addr = MAX;
`else
                     m_done = 1'b1;
`endif
                  end else begin
                     m_addr = m_addr - 23'd1;
                  end
               end
            end
         end
      end
   end

   initial begin
      n_vec       = 0;
      n_err       = 0;
      reset       = 1'b1;
      sample_tick = 1'b0;
      play        = 1'b0;
      dir         = 1'b0;
      restart     = 1'b0;
      rdy_man     = 1'b0;
      ovr_en      = 1'b1;
      ovr_word    = 32'hBBBB_AAAA;
      resp_dly    = 0;
      sb_en       = 1'b0;

      // asynchronous reset before any clock edge
      #2 reset = 1'b0;
      #1;
      check_eq("rst_addr", flash_address, 0);
      check_eq("rst_audio", audio_sample, 0);
      check_eq("rst_sv", sample_valid, 0);
      check_eq("rst_rs", read_start, 0);
      check_eq("rst_done", done, 0);
      step_clk();
      step_clk();
      play  = 1'b1;
      reset = 1'b1;

      // first forward word
      wait_rs("a_rs");
      check_eq("a_addr0", flash_address, 0);
      n_rs = 0;
      repeat (8) begin
         step_clk();
         n_rs += int'(read_start);
      end
      check_eq("a_one_rs", n_rs, 0);
      tick();
      check_eq("a_sv0", sample_valid, 1);
      check_eq("a_s0", audio_sample, 16'hAAAA);
      step_clk();
      check_eq("a_sv_pulse", sample_valid, 0);
      tick();
      check_eq("a_s1", audio_sample, 16'hBBBB);
      step_clk();
      check_eq("a_adv_rs", read_start, 1);
      check_eq("a_addr1", flash_address, 1);

      // backward restart
      ovr_word = 32'h2222_1111;
      dir      = 1'b1;
      restart  = 1'b1;
      step_clk();
      restart  = 1'b0;
      wait_rs("b_rs");
      check_eq("b_addr", flash_address, MAX);
      repeat (8) step_clk();
      tick();
      check_eq("b_s0", audio_sample, 16'h2222);
      tick();
      check_eq("b_s1", audio_sample, 16'h1111);
      step_clk();
      check_eq("b_rs2", read_start, 1);
      check_eq("b_addr2", flash_address, MAX - 23'd1);

      // forward step off the top address
      restart = 1'b1;
      step_clk();
      restart = 1'b0;
      wait_rs("d_rs");
      check_eq("d_addr", flash_address, MAX);
      dir = 1'b0;
      repeat (8) step_clk();
      tick();
      check_eq("d_s0", audio_sample, 16'h1111);
      tick();
      step_clk();
`ifdef SEQ_LOOP_EN
      check_eq("d_wrap_rs", read_start, 1);
      check_eq("d_wrap_addr", flash_address, 0);
      check_eq("d_wrap_done", done, 0);
`else
      check_eq("d_end_rs", read_start, 0);
      check_eq("d_end_done", done, 1);
      check_eq("d_end_addr", flash_address, MAX);
      n_rs = 0;
      repeat (10) begin
         step_clk();
         n_rs += int'(read_start);
      end
      check_eq("d_end_idle", n_rs, 0);
`endif

      // restart forward, walk to 0x10, restart mid-read
      ovr_en  = 1'b0;
      restart = 1'b1;
      step_clk();
      restart = 1'b0;
      wait_rs("c_rs0");
      check_eq("c_addr0", flash_address, 0);
      check_eq("c_done0", done, 0);
      for (int k = 0; k < 16; k++) begin
         repeat (8) step_clk();
         tick();
         tick();
         if (k == 15) begin
            resp_dly = 6;
            ovr_en   = 1'b1;
            ovr_word = 32'hDEAD_BEEF;
         end
         wait_rs("c_walk");
      end
      check_eq("c_addr10", flash_address, 23'h10);
      step_clk();
      restart = 1'b1;
      step_clk();
      restart  = 1'b0;
      ovr_word = 32'h1234_5678;
      wait_rs("c_rs1");
      check_eq("c_addr_rst", flash_address, 0);
      repeat (10) step_clk();
      tick();
      check_eq("c_s0", audio_sample, 16'h5678);
      tick();
      check_eq("c_s1", audio_sample, 16'h1234);

      // pause in the middle of a word
      ovr_word = 32'hCAFE_F00D;
      wait_rs("e_rs");
      check_eq("e_addr", flash_address, 1);
      repeat (10) step_clk();
      tick();
      check_eq("e_s0", audio_sample, 16'hF00D);
      play = 1'b0;
      repeat (5) begin
         tick();
         check_eq("e_pause_sv", sample_valid, 0);
      end
      play = 1'b1;
      tick();
      check_eq("e_resume_sv", sample_valid, 1);
      check_eq("e_s1", audio_sample, 16'hCAFE);

      // restart together with a tick
      wait_rs("f_rs");
      check_eq("f_addr", flash_address, 2);
      repeat (10) step_clk();
      restart     = 1'b1;
      sample_tick = 1'b1;
      step_clk();
      restart     = 1'b0;
      sample_tick = 1'b0;
      check_eq("f_sv0", sample_valid, 0);
      step_clk();
      check_eq("f_sv1", sample_valid, 0);
      wait_rs("f_rs1");
      check_eq("f_addr0", flash_address, 0);

      // reset in the middle of a read, stale ready after
      step_clk();
      reset = 1'b0;
      #1;
      check_eq("g_addr", flash_address, 0);
      check_eq("g_audio", audio_sample, 0);
      check_eq("g_sv", sample_valid, 0);
      check_eq("g_rs", read_start, 0);
      check_eq("g_done", done, 0);
      play = 1'b0;
      step_clk();
      step_clk();
      step_clk();
      reset = 1'b1;
      step_clk();
      rdy_man = 1'b1;
      step_clk();
      rdy_man = 1'b0;
      for (int k = 0; k < 6; k++) begin
         check_eq("g_stale_sv", sample_valid, 0);
         check_eq("g_stale_rs", read_start, 0);
         step_clk();
      end
      check_eq("g_audio_end", audio_sample, 0);
      check_eq("g_addr_end", flash_address, 0);

      // randomized run against the stream model
      resp_dly = 0;
      ovr_en   = 1'b0;
      dir      = 1'b0;
      play     = 1'b1;
      sb_en    = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         sample_tick = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) play = !play;
         if (i >= 200 && $urandom_range(0, 9) == 0)
            dir = ($urandom_range(0, 2) == 0);
         step_clk();
      end
      sample_tick = 1'b0;
      step_clk();
      sb_en = 1'b0;
      step_clk();

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
